// File: rtl/usb_rx_seq_ctrl.sv
// usb_rx_seq_ctrl: sequencer between the usb_rx decoder and the shared RX data
// buffer / AHB slave. It tracks packet phase from the registered rx_packet code,
// forwards data bytes as buffer writes, guards against overflow, and latches a
// final packet type and status per packet.
// Optional feature macro: USB_RX_SEQ_STATS_EN adds pkt_count / err_count outputs.
module usb_rx_seq_ctrl #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [2:0]       rx_packet,
  input  logic             store_rx_packet,
  input  logic [7:0]       rx_packet_data,
  input  logic [CNT_W-1:0] buffer_occupancy,
  input  logic             rx_ack,
  input  logic             flush,
  output logic             store_rx_data,
  output logic [7:0]       rx_data,
  output logic             clear_buffer,
  output logic             rx_data_ready,
  output logic [2:0]       rx_packet_type,
  output logic [CNT_W-1:0] rx_byte_count,
  output logic             rx_error,
  output logic             rx_busy
`ifdef USB_RX_SEQ_STATS_EN
  ,
  output logic [15:0]      pkt_count,
  output logic [15:0]      err_count
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_TOKEN, S_DATA, S_ERR, S_DONE} state_t;

  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(DEPTH);

  state_t         state;
  logic [2:0]     code_reg;
  logic [2:0]     pkt_code;
  logic [CNT_W:0] fill;
  logic           overflow;

  // A write issued last cycle is not yet visible in buffer_occupancy, so count it.
  assign fill     = {1'b0, buffer_occupancy} + {{CNT_W{1'b0}}, store_rx_data};
  assign overflow = (fill >= DEPTH_W);

  // Decisions are taken on the registered code so single-cycle glitches are aligned.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) code_reg <= 3'd0;
    else        code_reg <= rx_packet;
  end

  // Packet sequencer with all status outputs registered.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= S_IDLE;
      pkt_code       <= 3'd0;
      store_rx_data  <= 1'b0;
      rx_data        <= 8'd0;
      clear_buffer   <= 1'b0;
      rx_data_ready  <= 1'b0;
      rx_packet_type <= 3'd0;
      rx_byte_count  <= '0;
      rx_error       <= 1'b0;
      rx_busy        <= 1'b0;
    end else begin
      store_rx_data <= 1'b0;
      clear_buffer  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (flush) begin
            rx_byte_count <= '0;
            clear_buffer  <= 1'b1;
          end else if (state == S_DONE && rx_ack) begin
            state         <= S_IDLE;
            rx_data_ready <= 1'b0;
          end else if (code_reg != 3'd0) begin
            // A new code while DONE is an overrun: restart but flag the error.
            pkt_code <= code_reg;
            rx_busy  <= 1'b1;
            case (code_reg)
              3'd3, 3'd4: begin
                state         <= S_DATA;
                clear_buffer  <= 1'b1;
                rx_byte_count <= '0;
                rx_error      <= (state == S_DONE);
              end
              3'd7: begin
                state    <= S_ERR;
                rx_error <= 1'b1;
              end
              default: begin
                state         <= S_TOKEN;
                rx_byte_count <= '0;
                rx_error      <= (state == S_DONE);
              end
            endcase
          end
        end
        S_TOKEN: begin
          if (flush) begin
            rx_byte_count <= '0;
            clear_buffer  <= 1'b1;
          end
          if (code_reg == 3'd0) begin
            state          <= S_DONE;
            rx_packet_type <= pkt_code;
            rx_data_ready  <= 1'b1;
            rx_busy        <= 1'b0;
          end
        end
        S_DATA: begin
          if (flush) begin
            // Flush wins over a coincident byte; the byte is dropped.
            state         <= S_ERR;
            rx_error      <= 1'b1;
            rx_byte_count <= '0;
            clear_buffer  <= 1'b1;
          end else if (store_rx_packet && overflow) begin
            state    <= S_ERR;
            rx_error <= 1'b1;
          end else begin
            if (store_rx_packet) begin
              store_rx_data <= 1'b1;
              rx_data       <= rx_packet_data;
              if ({1'b0, rx_byte_count} < DEPTH_W)
                rx_byte_count <= rx_byte_count + 1'b1;
            end
            if (code_reg == 3'd0) begin
              state          <= S_DONE;
              rx_packet_type <= pkt_code;
              rx_data_ready  <= 1'b1;
              rx_busy        <= 1'b0;
            end
          end
        end
        S_ERR: begin
          rx_error <= 1'b1;
          if (flush) rx_byte_count <= '0;
          if (flush || code_reg == 3'd0) clear_buffer <= 1'b1;
          if (code_reg == 3'd0) begin
            state          <= S_DONE;
            rx_packet_type <= 3'd7;
            rx_data_ready  <= 1'b1;
            rx_busy        <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef USB_RX_SEQ_STATS_EN
  logic data_abort;
  logic enter_done;
  logic err_at_done;

  // Mirror the sequencer's DONE-entry condition for the statistics counters.
  always_comb begin
    data_abort  = (state == S_DATA) && (flush || (store_rx_packet && overflow));
    enter_done  = (code_reg == 3'd0) &&
                  ((state == S_TOKEN) || (state == S_ERR) || (state == S_DATA && !data_abort));
    err_at_done = (state == S_ERR) || rx_error;
  end

  // Saturating packet and error counters.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pkt_count <= 16'd0;
      err_count <= 16'd0;
    end else if (enter_done) begin
      if (pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
      if (err_at_done && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_seq_ctrl.sv
// Directed testbench for usb_rx_seq_ctrl (DEPTH=64, CNT_W=7).
module tb_usb_rx_seq_ctrl;
  logic       clk = 1'b0;
  logic       n_rst;
  logic [2:0] rx_packet;
  logic       store_rx_packet;
  logic [7:0] rx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       rx_ack;
  logic       flush;
  logic       store_rx_data;
  logic [7:0] rx_data;
  logic       clear_buffer;
  logic       rx_data_ready;
  logic [2:0] rx_packet_type;
  logic [6:0] rx_byte_count;
  logic       rx_error;
  logic       rx_busy;
`ifdef USB_RX_SEQ_STATS_EN
  logic [15:0] pkt_count;
  logic [15:0] err_count;
`endif

  int total = 0;
  int bad   = 0;

  usb_rx_seq_ctrl #(.DEPTH(64), .CNT_W(7)) dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .store_rx_packet(store_rx_packet),
    .rx_packet_data(rx_packet_data), .buffer_occupancy(buffer_occupancy), .rx_ack(rx_ack),
    .flush(flush), .store_rx_data(store_rx_data), .rx_data(rx_data),
    .clear_buffer(clear_buffer), .rx_data_ready(rx_data_ready),
    .rx_packet_type(rx_packet_type), .rx_byte_count(rx_byte_count), .rx_error(rx_error),
    .rx_busy(rx_busy)
`ifdef USB_RX_SEQ_STATS_EN
    , .pkt_count(pkt_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".store"}, 16'(store_rx_data), 16'd0);
    check({tag, ".data"},  16'(rx_data), 16'd0);
    check({tag, ".clr"},   16'(clear_buffer), 16'd0);
    check({tag, ".rdy"},   16'(rx_data_ready), 16'd0);
    check({tag, ".type"},  16'(rx_packet_type), 16'd0);
    check({tag, ".cnt"},   16'(rx_byte_count), 16'd0);
    check({tag, ".err"},   16'(rx_error), 16'd0);
    check({tag, ".busy"},  16'(rx_busy), 16'd0);
  endtask

  task automatic ack_done();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
    check("ack.rdy", 16'(rx_data_ready), 16'd0);
  endtask

  initial begin
    n_rst = 1'b0; rx_packet = 3'd0; store_rx_packet = 1'b0; rx_packet_data = 8'd0;
    buffer_occupancy = 7'd0; rx_ack = 1'b0; flush = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    n_rst = 1'b1;
    tick();

    // IN token
    rx_packet = 3'd2; tick(); tick();
    check("in.busy", 16'(rx_busy), 16'd1);
    check("in.rdy0", 16'(rx_data_ready), 16'd0);
    rx_packet = 3'd0; tick();
    check("in.busy2", 16'(rx_busy), 16'd1);
    tick();
    check("in.rdy", 16'(rx_data_ready), 16'd1);
    check("in.type", 16'(rx_packet_type), 16'd2);
    check("in.cnt", 16'(rx_byte_count), 16'd0);
    check("in.busy3", 16'(rx_busy), 16'd0);
    check("in.store", 16'(store_rx_data), 16'd0);
    ack_done();

    // DATA0 with D3, F0
    rx_packet = 3'd3; tick(); tick();
    check("d0.clr", 16'(clear_buffer), 16'd1);
    store_rx_packet = 1'b1; rx_packet_data = 8'hD3; tick();
    check("d0.clr_off", 16'(clear_buffer), 16'd0);
    check("d0.st1", 16'(store_rx_data), 16'd1);
    check("d0.b1", 16'(rx_data), 16'h00D3);
    rx_packet_data = 8'hF0; tick();
    check("d0.st2", 16'(store_rx_data), 16'd1);
    check("d0.b2", 16'(rx_data), 16'h00F0);
    store_rx_packet = 1'b0; rx_packet = 3'd0; tick();
    check("d0.st_off", 16'(store_rx_data), 16'd0);
    tick();
    check("d0.rdy", 16'(rx_data_ready), 16'd1);
    check("d0.type", 16'(rx_packet_type), 16'd3);
    check("d0.cnt", 16'(rx_byte_count), 16'd2);
    check("d0.err", 16'(rx_error), 16'd0);
    ack_done();

    // flush in IDLE: count cleared, state unchanged
    flush = 1'b1; tick(); flush = 1'b0;
    check("fi.cnt", 16'(rx_byte_count), 16'd0);
    check("fi.clr", 16'(clear_buffer), 16'd1);
    check("fi.busy", 16'(rx_busy), 16'd0);
    check("fi.rdy", 16'(rx_data_ready), 16'd0);
    tick();

    // Overflow: occupancy 63, DATA1 with two back-to-back bytes
    buffer_occupancy = 7'd63;
    rx_packet = 3'd4; tick(); tick();
    store_rx_packet = 1'b1; rx_packet_data = 8'h11; tick();
    check("ov.st1", 16'(store_rx_data), 16'd1);
    check("ov.b1", 16'(rx_data), 16'h0011);
    rx_packet_data = 8'h22; tick();
    check("ov.st2", 16'(store_rx_data), 16'd0);
    check("ov.err", 16'(rx_error), 16'd1);
    check("ov.busy", 16'(rx_busy), 16'd1);
    store_rx_packet = 1'b0; rx_packet = 3'd0; tick();
    check("ov.clr0", 16'(clear_buffer), 16'd0);
    tick();
    check("ov.rdy", 16'(rx_data_ready), 16'd1);
    check("ov.type", 16'(rx_packet_type), 16'd7);
    check("ov.clr", 16'(clear_buffer), 16'd1);
    check("ov.cnt", 16'(rx_byte_count), 16'd1);
    tick();
    check("ov.clr_off", 16'(clear_buffer), 16'd0);
    ack_done();
    buffer_occupancy = 7'd0;

    // flush coincident with store during DATA
    rx_packet = 3'd3; tick(); tick();
    store_rx_packet = 1'b1; flush = 1'b1; rx_packet_data = 8'h55; tick();
    check("fl.store", 16'(store_rx_data), 16'd0);
    check("fl.clr", 16'(clear_buffer), 16'd1);
    check("fl.cnt", 16'(rx_byte_count), 16'd0);
    check("fl.err", 16'(rx_error), 16'd1);
    check("fl.busy", 16'(rx_busy), 16'd1);
    store_rx_packet = 1'b0; flush = 1'b0; tick();
    check("fl.clr_off", 16'(clear_buffer), 16'd0);
    rx_packet = 3'd0; tick(); tick();
    check("fl.type", 16'(rx_packet_type), 16'd7);
    ack_done();

    // Back-to-back: OUT token, then ACK without rx_ack
    rx_packet = 3'd1; tick(); tick();
    rx_packet = 3'd0; tick(); tick();
    check("bb.type1", 16'(rx_packet_type), 16'd1);
    check("bb.rdy1", 16'(rx_data_ready), 16'd1);
    rx_packet = 3'd5; tick(); tick();
    check("bb.err", 16'(rx_error), 16'd1);
    check("bb.rdy2", 16'(rx_data_ready), 16'd1);
    check("bb.busy", 16'(rx_busy), 16'd1);
    rx_ack = 1'b1; tick(); rx_ack = 1'b0;
    check("bb.ack_ign", 16'(rx_data_ready), 16'd1);
    rx_packet = 3'd0; tick(); tick();
    check("bb.type5", 16'(rx_packet_type), 16'd5);
    check("bb.err2", 16'(rx_error), 16'd1);
    check("bb.busy2", 16'(rx_busy), 16'd0);
    ack_done();

    // Reset mid-DATA after three bytes
    rx_packet = 3'd3; tick(); tick();
    store_rx_packet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_packet_data = 8'(8'hA0 + i);
      tick();
    end
    store_rx_packet = 1'b0;
    check("rs.cnt3", 16'(rx_byte_count), 16'd3);
    n_rst = 1'b0; #1;
    check_all_zero("rs");
`ifdef USB_RX_SEQ_STATS_EN
    check("rs.pkt", pkt_count, 16'd0);
    check("rs.errc", err_count, 16'd0);
`endif
    rx_packet = 3'd0; tick(); n_rst = 1'b1; tick();
    rx_packet = 3'd6; tick(); tick();
    rx_packet = 3'd0; tick(); tick();
    check("rs.type", 16'(rx_packet_type), 16'd6);
    check("rs.err", 16'(rx_error), 16'd0);
    check("rs.cnt", 16'(rx_byte_count), 16'd0);
    check("rs.rdy", 16'(rx_data_ready), 16'd1);
`ifdef USB_RX_SEQ_STATS_EN
    check("rs.pkt1", pkt_count, 16'd1);
`endif
    ack_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
